// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse message scheduler.
package morse_pkg;

    localparam int PATTERN_BITS = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // 15-unit line pattern per decimal digit, bit 14 goes out first.
    // Only called with validated digits (0..9); others map to a silent line.
    function automatic logic [PATTERN_BITS-1:0] pattern_of(input logic [3:0] d);
        logic [PATTERN_BITS-1:0] p;
        case (d)
            4'd0:    p = 15'b111111111111111;
            4'd1:    p = 15'b011111111111100;
            4'd2:    p = 15'b001111111110000;
            4'd3:    p = 15'b000111111000000;
            4'd4:    p = 15'b000011100000000;
            4'd5:    p = 15'b000000000000000;
            4'd6:    p = 15'b111000000000000;
            4'd7:    p = 15'b111111000000000;
            4'd8:    p = 15'b111111111000000;
            4'd9:    p = 15'b111111111111000;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_unit_shifter.sv
// Plays one 15-unit pattern onto a single line, each unit TICK_DIV cycles long.
// Zeros shift in behind the pattern, so the line idles low once it is done.
module morse_unit_shifter
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [PATTERN_BITS-1:0] pattern_i,
    output logic                    bit_out_o,
    output logic                    last_unit_done_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [3:0]    UNIT_LAST = 4'(PATTERN_BITS - 1);

    logic [PATTERN_BITS-1:0] sh_q;
    logic [TW-1:0]           tick_q;
    logic [3:0]              unit_q;
    logic                    active_q;
    logic                    tick_end;

    assign tick_end         = active_q && (tick_q == TICK_LAST);
    assign last_unit_done_o = tick_end && (unit_q == UNIT_LAST);
    assign bit_out_o        = sh_q[PATTERN_BITS-1];

    // Tick divider and shift register; a load restarts unit timing from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q     <= '0;
            tick_q   <= '0;
            unit_q   <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            sh_q     <= pattern_i;
            tick_q   <= '0;
            unit_q   <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (tick_end) begin
                tick_q <= '0;
                sh_q   <= {sh_q[PATTERN_BITS-2:0], 1'b0};
                unit_q <= unit_q + 4'd1;
                if (unit_q == UNIT_LAST)
                    active_q <= 1'b0;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_msg_scheduler.sv
// Accepts a BCD message and sequences its digits as Morse patterns on one line,
// with a low gap between digits and a one-cycle done pulse at the end.
module morse_msg_scheduler
    import morse_pkg::*;
#(
    parameter int MAX_DIGITS = 8,
    parameter int TICK_DIV   = 4,
    parameter int GAP_UNITS  = 3,
    parameter int LEN_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [4*MAX_DIGITS-1:0] msg_digits,
    input  logic [LEN_W-1:0]        msg_len,
    output logic                    mors,
    output logic                    busy,
    output logic [LEN_W-1:0]        digit_idx,
    output logic                    done,
    output logic                    err
);

    localparam int GAP_CYC = GAP_UNITS * TICK_DIV;
    localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    state_e                  state_q;
    logic [4*MAX_DIGITS-1:0] digits_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        idx_q;
    logic [GW-1:0]           gap_q;
    logic                    ready_q, busy_q, done_q, err_q;

    logic                    accept, msg_ok, last_unit, last_digit, gap_end;
    logic [LEN_W-1:0]        nxt_idx;
    logic [3:0]              nxt_digit;
    logic                    load;
    logic [PATTERN_BITS-1:0] load_pat;

    assign accept     = msg_valid && ready_q;
    assign last_digit = (idx_q == len_q - 1'b1);
    assign gap_end    = (state_q == ST_GAP) && (gap_q == GAP_LAST);
    assign nxt_idx    = idx_q + 1'b1;

    // Message validation: length in range and every digit in use is BCD.
    always_comb begin
        msg_ok = (msg_len != '0) && (int'(msg_len) <= MAX_DIGITS);
        for (int k = 0; k < MAX_DIGITS; k++)
            if ((k < int'(msg_len)) && (msg_digits[4*k +: 4] > 4'd9))
                msg_ok = 1'b0;
    end

    // Select the next stored digit and decide when the shifter gets a new pattern.
    always_comb begin
        nxt_digit = '0;
        for (int k = 0; k < MAX_DIGITS; k++)
            if (nxt_idx == LEN_W'(k))
                nxt_digit = digits_q[4*k +: 4];
        load     = 1'b0;
        load_pat = pattern_of(nxt_digit);
        if (accept && msg_ok) begin
            load     = 1'b1;
            load_pat = pattern_of(msg_digits[3:0]);
        end else if (state_q == ST_SHIFT && last_unit && !last_digit && GAP_UNITS == 0) begin
            load = 1'b1;
        end else if (gap_end) begin
            load = 1'b1;
        end
    end

    morse_unit_shifter #(.TICK_DIV(TICK_DIV)) u_shifter (
        .clk              (clk),
        .rst              (rst),
        .load_i           (load),
        .pattern_i        (load_pat),
        .bit_out_o        (mors),
        .last_unit_done_o (last_unit)
    );

    // Scheduler FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            digits_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    state_q <= ST_IDLE;
                    if (accept) begin
                        if (msg_ok) begin
                            digits_q <= msg_digits;
                            len_q    <= msg_len;
                            idx_q    <= '0;
                            state_q  <= ST_SHIFT;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (last_unit) begin
                        if (last_digit) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else if (GAP_UNITS > 0) begin
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end else begin
                            idx_q <= nxt_idx;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        state_q <= ST_SHIFT;
                        idx_q   <= nxt_idx;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign msg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_morse_msg_scheduler.sv
// Directed bench for morse_msg_scheduler with TICK_DIV=2, GAP_UNITS=3.
// Cycle T is the cycle in which an accepted offer is presented; after each
// step() the bench sits 1ns into the next cycle and samples there.
module tb_morse_msg_scheduler;

    localparam int MAXD = 8;
    localparam int LW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            msg_valid = 1'b0;
    logic [4*MAXD-1:0] msg_digits = '0;
    logic [LW-1:0]   msg_len = '0;
    logic            msg_ready, mors, busy, done, err;
    logic [LW-1:0]   digit_idx;

    int n_chk  = 0;
    int n_fail = 0;

    morse_msg_scheduler #(
        .MAX_DIGITS(MAXD), .TICK_DIV(2), .GAP_UNITS(3), .LEN_W(LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_digits (msg_digits),
        .msg_len    (msg_len),
        .mors       (mors),
        .busy       (busy),
        .digit_idx  (digit_idx),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [14:0] p3;
    logic        e_mors;
    logic        saw_done;

    initial begin
        p3 = 15'b000111111000000;

        // 1: reset state
        rst = 1'b1;
        step(); step();
        check("rst mors",  32'(mors), 32'd0);
        check("rst ready", 32'(msg_ready), 32'd1);
        check("rst busy",  32'(busy), 32'd0);
        check("rst done",  32'(done), 32'd0);
        check("rst err",   32'(err), 32'd0);
        check("rst idx",   32'(digit_idx), 32'd0);
        rst = 1'b0;
        step();

        // 2: single digit 5, silent line for 30 cycles, done at T+31
        msg_digits = 32'h5; msg_len = 4'd1; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (k <= 30) begin
                check($sformatf("t2 mors k=%0d", k), 32'(mors), 32'd0);
                check($sformatf("t2 busy k=%0d", k), 32'(busy), 32'd1);
                check($sformatf("t2 done k=%0d", k), 32'(done), 32'd0);
            end else begin
                check("t2 done@31",  32'(done), 32'd1);
                check("t2 ready@31", 32'(msg_ready), 32'd1);
                check("t2 busy@31",  32'(busy), 32'd0);
                check("t2 mors@31",  32'(mors), 32'd0);
            end
            step();
        end
        check("t2 done clears", 32'(done), 32'd0);

        // 3 + 6: digits {0,4}; a second message (digit 6) is held offered throughout
        msg_digits = 32'h40; msg_len = 4'd2; msg_valid = 1'b1;
        step();
        msg_digits = 32'h6; msg_len = 4'd1;
        for (int k = 1; k <= 68; k++) begin
            if (k <= 30)                  e_mors = 1'b1;
            else if (k >= 45 && k <= 50)  e_mors = 1'b1;
            else if (k == 68)             e_mors = 1'b1;
            else                          e_mors = 1'b0;
            check($sformatf("t3 mors k=%0d", k), 32'(mors), 32'(e_mors));
            if (k <= 66) begin
                check($sformatf("t3 busy k=%0d", k),  32'(busy), 32'd1);
                check($sformatf("t3 ready k=%0d", k), 32'(msg_ready), 32'd0);
                check($sformatf("t3 done k=%0d", k),  32'(done), 32'd0);
                check($sformatf("t3 idx k=%0d", k),   32'(digit_idx), (k >= 37) ? 32'd1 : 32'd0);
            end else if (k == 67) begin
                check("t3 done@67",  32'(done), 32'd1);
                check("t3 ready@67", 32'(msg_ready), 32'd1);
                check("t3 busy@67",  32'(busy), 32'd0);
            end else begin
                check("t6 busy@68",  32'(busy), 32'd1);
                check("t6 idx@68",   32'(digit_idx), 32'd0);
                check("t6 done@68",  32'(done), 32'd0);
                msg_valid = 1'b0;
            end
            if (k < 68) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // 4: rejected offers produce an err pulse and leave the line idle
        msg_digits = 32'hC3; msg_len = 4'd2; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        check("t4a err",   32'(err), 32'd1);
        check("t4a mors",  32'(mors), 32'd0);
        check("t4a busy",  32'(busy), 32'd0);
        check("t4a ready", 32'(msg_ready), 32'd1);
        step();
        check("t4a err clears", 32'(err), 32'd0);

        msg_digits = 32'h3; msg_len = 4'd0; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        check("t4b err",  32'(err), 32'd1);
        check("t4b busy", 32'(busy), 32'd0);
        step();

        msg_digits = 32'h3; msg_len = 4'd9; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        check("t4c err len>max", 32'(err), 32'd1);
        check("t4c busy",        32'(busy), 32'd0);
        step();

        // digit 1 (=12) is beyond msg_len, so it is never validated
        msg_digits = 32'hC3; msg_len = 4'd1; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        check("t4d err", 32'(err), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            if (k <= 30) begin
                check($sformatf("t4d mors k=%0d", k), 32'(mors), 32'(p3[14 - (k - 1) / 2]));
                check($sformatf("t4d busy k=%0d", k), 32'(busy), 32'd1);
            end else begin
                check("t4d done@31", 32'(done), 32'd1);
            end
            step();
        end

        // 5: reset mid-message aborts with no done pulse afterwards
        msg_digits = 32'h0; msg_len = 4'd1; msg_valid = 1'b1;
        step();
        msg_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("t5 mors k=%0d", k), 32'(mors), 32'd1);
            if (k < 10) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5 mors@11",  32'(mors), 32'd0);
        check("t5 busy@11",  32'(busy), 32'd0);
        check("t5 ready@11", 32'(msg_ready), 32'd1);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done || mors) saw_done = 1'b1;
            step();
        end
        check("t5 no done/mors after abort", 32'(saw_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
